// File: rtl/buffer_pkg.sv
// rtl/buffer_pkg.sv - shared Buffer constants and packer FSM state type
package buffer_pkg;

    localparam int DEF_SIZE  = 16;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_K     = 8;
    localparam int DEF_J     = 4;

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        WAIT_SPACE = 2'd1,
        LOAD       = 2'd2
    } state_t;

endpackage

// File: rtl/buffer_packer_if.sv
// rtl/buffer_packer_if.sv - upstream word handshake between producer and packer
interface buffer_packer_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/buffer_packer_occ_counter.sv
// rtl/buffer_packer_occ_counter.sv - Buffer occupancy tracking and read qualification
module occ_counter
    import buffer_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int K    = DEF_K,
    parameter int J    = DEF_J
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld,
    input  logic                 rd_en,
    output logic [$clog2(SIZE):0] occupancy,
    output logic                 rd_valid
);

    localparam int OW = $clog2(SIZE) + 1;

    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;

    // A read only counts when J words are actually present; load and read net out
    always_comb begin
        rd_valid = rd_en && (occ_q >= OW'(J));
        occ_d    = occ_q + (ld ? OW'(K) : '0) - (rd_valid ? OW'(J) : '0);
    end

    // Occupancy register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: rtl/buffer_packer.sv
// rtl/buffer_packer.sv - packs K upstream words into one Buffer write (optional err via BUFFER_PACKER_ERR_EN)
module buffer_packer
    import buffer_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int WIDTH = DEF_WIDTH,
    parameter int K     = DEF_K,
    parameter int J     = DEF_J
) (
    input  logic                      clk,
    input  logic                      rst,
    buffer_packer_if.slave            in_if,
    input  logic                      rd_en,
    output logic                      ld,
    output logic [$clog2(SIZE)-1:0]   write_add,
    output logic [WIDTH*K-1:0]        par_in,
    output logic [$clog2(SIZE):0]     occupancy
`ifdef BUFFER_PACKER_ERR_EN
    ,
    output logic                      err
`endif
);

    localparam int AW = $clog2(SIZE);
    localparam int OW = AW + 1;
    localparam int CW = $clog2(K + 1);

    state_t             state_q;
    state_t             state_d;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic [WIDTH*K-1:0] par_q;
    logic [WIDTH*K-1:0] par_d;
    logic [AW-1:0]      wadd_q;
    logic [AW-1:0]      wadd_d;
    logic               in_ready;
    logic               accept;
    logic               grp_done;
    logic               space_ok;
    logic               rd_valid;

    assign in_if.in_ready = in_ready;
    assign accept         = in_if.in_valid && in_ready;
    assign grp_done       = accept && (cnt_q == CW'(K - 1));
    // Uses the registered occupancy, so a same-cycle read never frees space early
    assign space_ok       = (occupancy <= OW'(SIZE - K));

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fill a group, wait for room, then strobe one write
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:       if (grp_done) state_d = WAIT_SPACE;
            WAIT_SPACE: if (space_ok) state_d = LOAD;
            LOAD:       state_d = FILL;
            default:    state_d = FILL;
        endcase
    end

    // FSM outputs: accept words only while filling, strobe write only in LOAD
    always_comb begin
        in_ready = 1'b0;
        ld       = 1'b0;
        case (state_q)
            FILL:    in_ready = 1'b1;
            LOAD:    ld       = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state: place words by arrival index, bump address after each write
    always_comb begin
        cnt_d  = cnt_q;
        par_d  = par_q;
        wadd_d = wadd_q;
        if (accept) begin
            par_d[int'(cnt_q)*WIDTH +: WIDTH] = in_if.in_data;
            cnt_d = grp_done ? '0 : cnt_q + 1'b1;
        end
        if (state_q == LOAD) begin
            wadd_d = wadd_q + AW'(K);
        end
    end

    // Datapath registers; a reset discards any partial group
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            par_q  <= '0;
            wadd_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            par_q  <= par_d;
            wadd_q <= wadd_d;
        end
    end

    assign par_in    = par_q;
    assign write_add = wadd_q;

    occ_counter #(
        .SIZE (SIZE),
        .K    (K),
        .J    (J)
    ) u_occ (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .rd_en     (rd_en),
        .occupancy (occupancy),
        .rd_valid  (rd_valid)
    );

`ifdef BUFFER_PACKER_ERR_EN
    logic err_q;

    // Sticky flag for a reader that asked for words that were not there
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (rd_en && !rd_valid) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    // Read qualification is only consumed by the error flag
    logic rd_valid_unused;
    assign rd_valid_unused = rd_valid;
`endif

endmodule
